// File: rtl/instr_word_encoder.sv
// Builds RV32 R-type / ADDI words from ALU operation requests and streams them into imem from word 0.
// Optional INSTR_ENC_NOP_PAD_EN: after the last request, fill the remaining words with NOP.
module instr_word_encoder #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DEPTH  = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_last,
   input  logic [3:0]        req_alu_op,
   input  logic              req_is_imm,
   input  logic [4:0]        req_rd,
   input  logic [4:0]        req_rs1,
   input  logic [4:0]        req_rs2,
   input  logic [11:0]       req_imm,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              busy,
   output logic              done,
   output logic              full,
   output logic              illegal,
   output logic [ADDR_W:0]   word_count
);

   localparam int unsigned      CNT_W    = ADDR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [31:0]      NOP_WORD = 32'h0000_0013;
   localparam logic [3:0]       OP_ADD   = 4'b0010;
   localparam logic [3:0]       OP_SUB   = 4'b0100;

`ifdef INSTR_ENC_NOP_PAD_EN
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PAD, S_DONE} state_e;
`else
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_e;
`endif

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   word_count_q, word_count_d;
   logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
   logic [31:0]        imem_wdata_q, imem_wdata_d;
   logic               imem_we_q, imem_we_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               full_q, full_d;
   logic               illegal_q, illegal_d;

   logic               req_legal;
   logic [2:0]         funct3;
   logic [6:0]         funct7;
   logic [31:0]        enc_word;
   logic               accept;
   logic [CNT_W-1:0]   count_inc;

   // Instruction encoding for the presented request
   always_comb begin
      funct3    = 3'd0;
      funct7    = (req_alu_op == OP_SUB) ? 7'h20 : 7'h00;
      req_legal = !req_alu_op[3] && (!req_is_imm || (req_alu_op == OP_ADD));
      case (req_alu_op[2:0])
         3'd0:    funct3 = 3'd7;
         3'd1:    funct3 = 3'd6;
         3'd2:    funct3 = 3'd0;
         3'd3:    funct3 = 3'd1;
         3'd4:    funct3 = 3'd0;
         3'd5:    funct3 = 3'd5;
         3'd6:    funct3 = 3'd2;
         default: funct3 = 3'd4;
      endcase
      if (req_is_imm)
         enc_word = {req_imm, req_rs1, 3'b000, req_rd, 7'h13};
      else
         enc_word = {funct7, req_rs2, req_rs1, funct3, req_rd, 7'h33};
   end

   assign req_ready = (state_q == S_LOAD) && (word_count_q < DEPTH_C);
   assign accept    = req_valid && req_ready;
   assign count_inc = word_count_q + CNT_W'(1);

   // Next-state and registered-output logic; the write pointer is the low bits of word_count
   always_comb begin
      state_d      = state_q;
      word_count_d = word_count_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      done_d       = done_q;
      full_d       = full_q;
      illegal_d    = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d      = S_LOAD;
               word_count_d = '0;
               done_d       = 1'b0;
               full_d       = 1'b0;
            end else if (state_q == S_DONE) begin
               done_d = 1'b1;
            end
         end
         S_LOAD: begin
            if (accept) begin
               if (req_legal) begin
                  imem_we_d    = 1'b1;
                  imem_addr_d  = word_count_q[ADDR_W-1:0];
                  imem_wdata_d = enc_word;
                  word_count_d = count_inc;
               end else begin
                  illegal_d = 1'b1;
               end
               if (req_last) begin
`ifdef INSTR_ENC_NOP_PAD_EN
                  state_d = (word_count_d < DEPTH_C) ? S_PAD : S_DONE;
`else
                  state_d = S_DONE;
`endif
               end else if (word_count_d == DEPTH_C) begin
                  full_d  = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
`ifdef INSTR_ENC_NOP_PAD_EN
         S_PAD: begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_count_q[ADDR_W-1:0];
            imem_wdata_d = NOP_WORD;
            word_count_d = count_inc;
            if (count_inc == DEPTH_C) state_d = S_DONE;
         end
`endif
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         word_count_q <= '0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         full_q       <= 1'b0;
         illegal_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         word_count_q <= word_count_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         full_q       <= full_d;
         illegal_q    <= illegal_d;
      end
   end

   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign full       = full_q;
   assign illegal    = illegal_q;
   assign word_count = word_count_q;

endmodule

// File: tb/tb_instr_word_encoder.sv
// Randomized bench for instr_word_encoder with a transaction-level reference model and per-cycle compare.
module tb_instr_word_encoder;

   localparam int AW   = 4;
   localparam int DP   = 6;
   localparam int MEMN = 16;
   localparam logic [31:0] MARK = 32'hDEAD_BEEF;
`ifdef INSTR_ENC_NOP_PAD_EN
   localparam bit PAD_EN = 1'b1;
`else
   localparam bit PAD_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n, start, req_valid, req_ready, req_last, req_is_imm;
   logic [3:0]    req_alu_op;
   logic [4:0]    req_rd, req_rs1, req_rs2;
   logic [11:0]   req_imm;
   logic          imem_we, busy, done, full, illegal;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic [AW:0]   word_count;

   instr_word_encoder #(.ADDR_W(AW), .DEPTH(DP)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .req_valid(req_valid), .req_ready(req_ready),
      .req_last(req_last), .req_alu_op(req_alu_op), .req_is_imm(req_is_imm), .req_rd(req_rd),
      .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm), .imem_we(imem_we),
      .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy), .done(done), .full(full),
      .illegal(illegal), .word_count(word_count)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_chk  = 0;
   int ill_seen = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
   endtask

   function automatic logic [31:0] ref_word(input int op, input bit is_imm, input int rd,
                                            input int rs1, input int rs2, input int imm);
      int f3tab [8] = '{7, 6, 0, 1, 0, 5, 2, 4};
      int f7;
      if (is_imm) return 32'((imm << 20) + (rs1 << 15) + (rd << 7) + 'h13);
      f7 = (op == 4) ? 'h20 : 0;
      return 32'((f7 << 25) + (rs2 << 20) + (rs1 << 15) + (f3tab[op] << 12) + (rd << 7) + 'h33);
   endfunction

   function automatic bit ref_legal(input int op, input bit is_imm);
      return (op < 8) && (!is_imm || op == 2);
   endfunction

   // Reference model: expected outputs for the cycle following each edge
   bit            m_load, m_pad, m_fin, m_done, m_full, e_we, e_ill;
   int            m_cnt;
   logic [AW-1:0] e_addr;
   logic [31:0]   e_wdata;
   logic [31:0]   mem_exp [MEMN];
   logic [31:0]   mem_dut [MEMN];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_load = 0; m_pad = 0; m_fin = 0; m_done = 0; m_full = 0;
         e_we = 0; e_ill = 0; m_cnt = 0;
      end else begin
         e_we = 0; e_ill = 0;
         if (m_load) begin
            if (req_valid && m_cnt < DP) begin
               if (ref_legal(int'(req_alu_op), req_is_imm)) begin
                  e_we = 1; e_addr = AW'(m_cnt);
                  e_wdata = ref_word(int'(req_alu_op), req_is_imm, int'(req_rd), int'(req_rs1),
                                     int'(req_rs2), int'(req_imm));
                  mem_exp[m_cnt] = e_wdata;
                  m_cnt++;
               end else begin
                  e_ill = 1;
               end
               if (req_last) begin
                  m_load = 0;
                  if (PAD_EN && m_cnt < DP) m_pad = 1; else m_fin = 1;
               end else if (m_cnt == DP) begin
                  m_load = 0; m_full = 1; m_fin = 1;
               end
            end
         end else if (m_pad) begin
            e_we = 1; e_addr = AW'(m_cnt); e_wdata = 32'h13;
            mem_exp[m_cnt] = e_wdata;
            m_cnt++;
            if (m_cnt == DP) begin m_pad = 0; m_fin = 1; end
         end else if (start) begin
            m_load = 1; m_fin = 0; m_done = 0; m_full = 0; m_cnt = 0;
            for (int i = 0; i < MEMN; i++) mem_exp[i] = MARK;
         end else if (m_fin) begin
            m_done = 1;
         end
      end
   end

   // Per-cycle compare, away from the active edge
   always @(negedge clk) begin
      chk("req_ready", 32'(req_ready), 32'(m_load && m_cnt < DP));
      chk("imem_we", 32'(imem_we), 32'(e_we));
      chk("busy", 32'(busy), 32'(m_load || m_pad));
      chk("done", 32'(done), 32'(m_done));
      chk("full", 32'(full), 32'(m_full));
      chk("illegal", 32'(illegal), 32'(e_ill));
      chk("word_count", 32'(word_count), 32'(m_cnt));
      if (imem_we && e_we) begin
         chk("imem_addr", 32'(imem_addr), 32'(e_addr));
         chk("imem_wdata", imem_wdata, e_wdata);
      end
      if (imem_we) mem_dut[imem_addr] = imem_wdata;
      if (illegal) ill_seen++;
   end

   task automatic do_start();
      for (int i = 0; i < MEMN; i++) mem_dut[i] = MARK;
      start = 1;
      @(negedge clk);
      start = 0;
      @(negedge clk);
   endtask

   task automatic send(input logic [3:0] op, input bit is_imm, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm,
                       input bit last, input bit stray_start, output bit acc);
      req_alu_op = op; req_is_imm = is_imm; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
      req_imm = imm; req_last = last; req_valid = 1; start = stray_start;
      acc = 0;
      for (int i = 0; i < 8 && !acc; i++) begin
         if (req_ready) acc = 1;
         @(negedge clk);
         start = 0;
      end
      req_valid = 0; req_last = 0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 40 && !done; i++) @(negedge clk);
      chk("done_reached", 32'(done), 32'd1);
   endtask

   task automatic check_mem();
      for (int i = 0; i < MEMN; i++) chk($sformatf("mem[%0d]", i), mem_dut[i], mem_exp[i]);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      rst_n = 0; start = 0; req_valid = 0; req_last = 0; req_alu_op = 0; req_is_imm = 0;
      req_rd = 0; req_rs1 = 0; req_rs2 = 0; req_imm = 0;
      for (int i = 0; i < MEMN; i++) mem_dut[i] = MARK;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_we", 32'(imem_we), 32'd0);
      chk("rst_word_count", 32'(word_count), 32'd0);
      #2 rst_n = 1;
      @(negedge clk);

      // ADD then SUB
      do_start();
      chk("start_ready", 32'(req_ready), 32'd1);
      send(4'd2, 0, 5'd3, 5'd1, 5'd2, 12'd0, 0, 0, acc);
      send(4'd4, 0, 5'd3, 5'd1, 5'd2, 12'd0, 1, 0, acc);
      chk("lit_wc2", 32'(word_count), 32'd2);
      wait_done();
      chk("lit_add", mem_dut[0], 32'h002081B3);
      chk("lit_sub", mem_dut[1], 32'h402081B3);
      check_mem();

      // ADDI with negative immediate
      do_start();
      send(4'd2, 1, 5'd5, 5'd0, 5'd0, 12'hFFF, 1, 0, acc);
      wait_done();
      chk("lit_addi", mem_dut[0], 32'hFFF00293);
      check_mem();

      // Two illegal requests, then a legal AND
      do_start();
      ill_seen = 0;
      send(4'd8, 0, 5'd1, 5'd1, 5'd1, 12'd0, 0, 0, acc);
      send(4'd1, 1, 5'd1, 5'd1, 5'd1, 12'd7, 0, 0, acc);
      send(4'd0, 0, 5'd1, 5'd2, 5'd3, 12'd0, 1, 0, acc);
      wait_done();
      chk("lit_ill_count", 32'(ill_seen), 32'd2);
      chk("lit_and_addr0", mem_dut[0], 32'h003170B3);
      check_mem();

      // Overfill without last
      do_start();
      for (int k = 0; k <= DP; k++) begin
         send(4'd2, 0, 5'(k), 5'd1, 5'd2, 12'd0, 0, 0, acc);
         chk($sformatf("fill_acc%0d", k), 32'(acc), 32'(k < DP));
      end
      wait_done();
      chk("lit_full", 32'(full), 32'd1);
      chk("lit_full_wc", 32'(word_count), 32'(DP));
      check_mem();

      // Randomized programs
      for (int p = 0; p < 14; p++) begin
         int len;
         do_start();
         len = int'($urandom_range(1, 8));
         for (int k = 0; k < len; k++) begin
            logic [3:0] op;
            bit imm_f;
            op = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(8, 15));
            imm_f = ($urandom_range(0, 3) == 0);
            if (imm_f && $urandom_range(0, 2) != 0) op = 4'd2;
            send(op, imm_f, 5'($urandom), 5'($urandom), 5'($urandom), 12'($urandom),
                 k == len - 1, $urandom_range(0, 9) == 0, acc);
            if (!acc) break;
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         wait_done();
         check_mem();
      end

      // Reset in the middle of a write burst
      do_start();
      send(4'd2, 0, 5'd1, 5'd1, 5'd1, 12'd0, 1, 0, acc);
      chk("abort_pre_we", 32'(imem_we), 32'd1);
      #2 rst_n = 0;
      #1;
      chk("abort_we", 32'(imem_we), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_wc", 32'(word_count), 32'd0);
      @(negedge clk);
      #2 rst_n = 1;
      @(negedge clk);
      do_start();
      send(4'd7, 0, 5'd9, 5'd10, 5'd11, 12'd0, 1, 0, acc);
      wait_done();
      check_mem();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
